brick_field: RTL and testbench
==============================

# brick_field

Brick-field state and collision engine for the brick breaker game. It holds the alive/dead bitmap of the brick grid and checks the ball position against the grid once per frame. On a hit it clears the struck bricks, pulses a bounce request back to the ball logic, and keeps the score. It also produces the per-pixel brick mask that the brick renderer and colour compositor consume.

## Interface
Parameters:
- ROWS, 4, brick rows
- COLS, 8, brick columns (ROWS*COLS ≤ 64)
- BRICK_W, 80, brick width in pixels
- BRICK_H, 20, brick height in pixels
- TOP, 40, y of the grid's top edge; the grid's left edge is x=0
- BALL_SIZE, 8, ball square side in pixels

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- ball_x  in  10  ball top-left x
- ball_y  in  10  ball top-left y
- xPixel  in  10  current VGA pixel x
- yPixel  in  10  current VGA pixel y
- active_pixels  in  1  VGA active-region flag
- brick_on  out  1  registered: current pixel belongs to a live brick
- hit  out  1  one-cycle pulse: at least one brick cleared this frame
- bounce_y  out  1  one-cycle pulse coincident with hit; the ball negates its y velocity
- score  out  8  bricks cleared, saturating at 255
- level_clear  out  1  all bricks cleared; sticky until reset
- alive  out  ROWS*COLS  brick bitmap; bit index = row*COLS+col

## Operation
- Reset (rst=0, async) values: alive=all ones, score=0, hit=0, bounce_y=0, level_clear=0, brick_on=0, FSM=IDLE.
- FSM states: IDLE → CHECK (4 cycles, 2-bit corner counter 0..3) → COMMIT → IDLE.
- IDLE: when frame_tick=1, latch ball_x/ball_y, clear hit_mask, and go to CHECK.
- CHECK, one corner per cycle, in order:
  - corner 0 = (bx, by)
  - corner 1 = (bx+BALL_SIZE-1, by)
  - corner 2 = (bx, by+BALL_SIZE-1)
  - corner 3 = (bx+BALL_SIZE-1, by+BALL_SIZE-1)
- Corner sums are 11-bit; they do not wrap.
- A corner is in the grid when x < COLS*BRICK_W and TOP ≤ y < TOP+ROWS*BRICK_H. For an in-grid corner, col = x/BRICK_W and row = (y-TOP)/BRICK_H, computed by constant-compare chain, not a generic divider.
- If the corner is in the grid and alive[idx]=1, set hit_mask[idx]. Several corners on the same brick set one bit.
- COMMIT:
  - alive <= alive & ~hit_mask
  - score <= min(255, score + popcount(hit_mask))
  - hit = bounce_y = (hit_mask != 0) for this one cycle
  - level_clear <= 1 when the next alive value is 0
- frame_tick arriving outside IDLE is ignored. Ball inputs are only sampled in IDLE.
- Pixel path, every cycle, registered: brick_on <= active_pixels & pixel in grid & alive[idx(pixel)] & not a gap pixel.
  - Gap pixel: local x == 0 or local y == 0 within the brick, giving a 1-pixel black border.
  - brick_on is independent of the FSM and always reads the current alive register.

## Timing
- frame_tick high at edge k → CHECK at cycles k+1..k+4 → COMMIT at k+5. hit/bounce_y are high during cycle k+5 only. The new alive/score/level_clear values are visible from k+6.
- The whole update takes 6 cycles, far inside vertical blank; no pixel of the active frame sees a partially updated bitmap.
- brick_on has 1-cycle latency from xPixel/yPixel/active_pixels. The compositor tolerates this 1-pixel shift.
- Reset asserted mid-CHECK or mid-COMMIT: all state returns to reset values immediately, with no partial alive update. The first frame_tick after release starts a fresh check.
- Score saturation: at score=254 with 4 bricks hit, score becomes 255 and stays there.
- A hit on the last live brick: level_clear rises at k+6 together with alive=0. Further frame_ticks produce no hit.

## Test plan
- Reset: hold rst=0 with random inputs → alive=32'hFFFFFFFF, score=0, hit=0, level_clear=0, brick_on=0.
- Single hit: ball (10,45), frame_tick → hit/bounce_y high exactly at cycle k+5; alive[0]=0 and score=1 at k+6; a second tick at the same position → no hit, score stays 1.
- Four-brick straddle: ball (76,56) → bricks 0, 1, 8, 9 cleared, score=4, a single one-cycle hit pulse.
- Miss and edges: ball (300,300), ball (636,30), and ball (0,TOP+ROWS*BRICK_H) → no hit, alive unchanged; a frame_tick during CHECK is ignored (only one COMMIT occurs).
- Clear all: walk the ball over all 32 bricks → score=32, level_clear=1 after the last COMMIT and held; rst pulse mid-CHECK restores full alive and score=0.
- Render: sweep pixels with active_pixels=1 → brick_on=1 at (5,45) one cycle later, 0 at (80,45) (gap), 0 at (5,45) after brick 0 is cleared, 0 whenever active_pixels=0.

Source files
------------

// File: rtl/brick_field.sv
// brick_field: brick grid bitmap, once-per-frame ball/brick collision check,
// score keeping and the registered per-pixel brick mask for the renderer.
module brick_field #(
  parameter int ROWS      = 4,
  parameter int COLS      = 8,
  parameter int BRICK_W   = 80,
  parameter int BRICK_H   = 20,
  parameter int TOP       = 40,
  parameter int BALL_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic [9:0]           ball_x,
  input  logic [9:0]           ball_y,
  input  logic [9:0]           xPixel,
  input  logic [9:0]           yPixel,
  input  logic                 active_pixels,
  output logic                 brick_on,
  output logic                 hit,
  output logic                 bounce_y,
  output logic [7:0]           score,
  output logic                 level_clear,
  output logic [ROWS*COLS-1:0] alive
);
  localparam int N  = ROWS * COLS;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int GW = COLS * BRICK_W;
  localparam int GB = TOP + ROWS * BRICK_H;

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;

  state_t       state_q, state_d;
  logic [9:0]   bx_q, bx_d, by_q, by_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [N-1:0] mask_q, mask_d, alive_q, alive_d;
  logic [7:0]   score_q, score_d;
  logic         hit_q, hit_d, lc_q, lc_d, on_q, on_d;
  int           cx, cy, pc, pr, sum;
  logic [IW-1:0] cidx, pidx;
  logic         c_in;

  // Quotient by a chain of constant compares: largest k < n with k*step <= v.
  function automatic int quot(input int v, input int step, input int n);
    int q;
    q = 0;
    for (int k = 1; k < n; k++) if (v >= k * step) q = k;
    return q;
  endfunction

  always_comb begin
    cx = int'(bx_q) + (cnt_q[0] ? BALL_SIZE - 1 : 0);
    cy = int'(by_q) + (cnt_q[1] ? BALL_SIZE - 1 : 0);
    c_in = cx < GW && cy >= TOP && cy < GB;
    cidx = IW'(quot(cy - TOP, BRICK_H, ROWS) * COLS + quot(cx, BRICK_W, COLS));
    mask_d = mask_q;
    if (state_q == CHECK && c_in && alive_q[cidx]) mask_d[cidx] = 1'b1;
    if (state_q == IDLE && frame_tick) mask_d = '0;
    state_d = state_q == IDLE  ? (frame_tick ? CHECK : IDLE) :
              state_q == CHECK ? (cnt_q == 2'd3 ? COMMIT : CHECK) : IDLE;
    bx_d = state_q == IDLE && frame_tick ? ball_x : bx_q;
    by_d = state_q == IDLE && frame_tick ? ball_y : by_q;
    cnt_d = state_q == CHECK ? cnt_q + 2'd1 : 2'd0;
    hit_d = state_q == CHECK && cnt_q == 2'd3 && mask_d != '0;
    alive_d = state_q == COMMIT ? alive_q & ~mask_q : alive_q;
    sum = int'(score_q) + $countones(mask_q);
    score_d = state_q == COMMIT ? (sum > 255 ? 8'd255 : 8'(sum)) : score_q;
    lc_d = lc_q | (state_q == COMMIT && alive_d == '0);
    pc = quot(int'(xPixel), BRICK_W, COLS);
    pr = quot(int'(yPixel) - TOP, BRICK_H, ROWS);
    pidx = IW'(pr * COLS + pc);
    // Local x/y of zero inside a brick is the 1-pixel black border.
    on_d = active_pixels && int'(xPixel) < GW && int'(yPixel) >= TOP &&
           int'(yPixel) < GB && alive_q[pidx] && int'(xPixel) != pc * BRICK_W &&
           int'(yPixel) - TOP != pr * BRICK_H;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      bx_q    <= '0;
      by_q    <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      alive_q <= '1;
      score_q <= '0;
      hit_q   <= 1'b0;
      lc_q    <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      alive_q <= alive_d;
      score_q <= score_d;
      hit_q   <= hit_d;
      lc_q    <= lc_d;
      on_q    <= on_d;
    end

  assign brick_on    = on_q;
  assign hit         = hit_q;
  assign bounce_y    = hit_q;
  assign score       = score_q;
  assign level_clear = lc_q;
  assign alive       = alive_q;
endmodule

// File: tb/tb_brick_field.sv
// tb_brick_field: scoreboard bench for brick_field; expected frame results are
// queued at each frame_tick and compared when the commit becomes visible.
module tb_brick_field;
  localparam int ROWS = 4, COLS = 8, BW = 80, BH = 20, TOP = 40, BS = 8, N = 32;

  logic clk = 0, rst = 0, frame_tick = 0, active_pixels = 0;
  logic [9:0] ball_x = 0, ball_y = 0, xPixel = 0, yPixel = 0;
  logic brick_on, hit, bounce_y, level_clear;
  logic [7:0] score;
  logic [N-1:0] alive;

  int n_cmp = 0, n_bad = 0;
  logic [N-1:0] m_alive = '1;
  int m_score = 0;
  logic m_lc = 0;

  typedef struct {logic [N-1:0] alive; logic [7:0] score; logic lc; logic hit;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  brick_field dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .ball_x(ball_x), .ball_y(ball_y),
    .xPixel(xPixel), .yPixel(yPixel), .active_pixels(active_pixels), .brick_on(brick_on),
    .hit(hit), .bounce_y(bounce_y), .score(score), .level_clear(level_clear), .alive(alive)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] corners(input int bx, input int by);
    logic [N-1:0] m;
    int x, y;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      x = bx + ((k & 1) != 0 ? BS - 1 : 0);
      y = by + ((k & 2) != 0 ? BS - 1 : 0);
      if (x < COLS * BW && y >= TOP && y < TOP + ROWS * BH) m[(y - TOP) / BH * COLS + x / BW] = 1'b1;
    end
    return m & m_alive;
  endfunction

  function automatic logic pix_exp(input int x, input int y, input logic a);
    if (!a || x >= COLS * BW || y < TOP || y >= TOP + ROWS * BH) return 1'b0;
    return m_alive[(y - TOP) / BH * COLS + x / BW] && x % BW != 0 && (y - TOP) % BH != 0;
  endfunction

  task automatic model_reset();
    m_alive = '1;
    m_score = 0;
    m_lc = 0;
  endtask

  // One frame: tick at edge E0, watch hit/bounce over E0..E0+11.
  task automatic frame(input int bx, input int by, input bit extra);
    logic [N-1:0] m;
    logic [11:0] hp, bp;
    exp_t e;
    m = corners(bx, by);
    m_alive &= ~m;
    m_score = (m_score + $countones(m) > 255) ? 255 : m_score + $countones(m);
    m_lc = m_lc | (m_alive == '0);
    sb.push_back('{m_alive, 8'(m_score), m_lc, m != '0});
    ball_x = 10'(bx);
    ball_y = 10'(by);
    frame_tick = 1;
    hp = '0;
    bp = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      frame_tick = extra && i == 1;
      if (extra && i == 1) begin
        ball_x = 10'd596;
        ball_y = 10'd106;
      end
      hp[i] = hit;
      bp[i] = bounce_y;
      if (i == 5) begin
        e = sb.pop_front();
        check("alive", alive, e.alive);
        check("score", score, e.score);
        check("level_clear", level_clear, e.lc);
      end
    end
    check("hit_pulse", hp, e.hit ? 12'h010 : 12'h000);
    check("bounce_pulse", bp, e.hit ? 12'h010 : 12'h000);
  endtask

  task automatic pix(input int x, input int y, input logic a);
    xPixel = 10'(x);
    yPixel = 10'(y);
    active_pixels = a;
    @(posedge clk);
    #1;
    check("brick_on", brick_on, pix_exp(x, y, a));
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      frame_tick = 1'($urandom);
      ball_x = 10'($urandom);
      ball_y = 10'($urandom);
      xPixel = 10'($urandom);
      yPixel = 10'($urandom);
      active_pixels = 1'($urandom);
    end
    check("rst_alive", alive, 32'hFFFF_FFFF);
    check("rst_score", score, 0);
    check("rst_hit", hit, 0);
    check("rst_bounce", bounce_y, 0);
    check("rst_lc", level_clear, 0);
    check("rst_brick_on", brick_on, 0);
    frame_tick = 0;
    active_pixels = 0;
    rst = 1;
    model_reset();

    pix(5, 45, 1);
    pix(80, 45, 1);
    pix(5, 40, 1);
    pix(5, 45, 0);
    for (int i = 0; i < 30; i++)
      pix($urandom_range(0, 700), $urandom_range(0, 140), $urandom_range(0, 3) != 0);

    frame(10, 45, 0);
    frame(10, 45, 0);
    check("single_score", score, 1);
    pix(5, 45, 1);

    rst = 0;
    #2;
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_pulse_alive", alive, 32'hFFFF_FFFF);

    frame(76, 56, 0);
    check("straddle_alive", alive, 32'hFFFF_FCFC);
    check("straddle_score", score, 4);
    frame(300, 300, 0);
    frame(636, 30, 0);
    frame(0, TOP + ROWS * BH, 0);
    frame(200, 70, 1);

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) frame(c * BW + 36, TOP + r * BH + 6, 0);
    check("all_score", score, 32);
    check("all_lc", level_clear, 1);
    frame(10, 45, 0);
    pix(45, 50, 1);

    ball_x = 10;
    ball_y = 45;
    frame_tick = 1;
    @(posedge clk);
    #1;
    frame_tick = 0;
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    check("mid_rst_alive", alive, 32'hFFFF_FFFF);
    check("mid_rst_score", score, 0);
    check("mid_rst_lc", level_clear, 0);
    check("mid_rst_hit", hit, 0);
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    frame(10, 45, 0);
    pix(5, 45, 1);
    pix(85, 45, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
